// File: rtl/ip_arp_resolver_pkg.sv
// Shared widths, table depth and index-width helper for the next-hop ARP resolver.
package ip_arp_resolver_pkg;

  localparam int IP_W                          = 32;
  localparam int MAC_W                         = 48;
  localparam int ROUTER_OP_LUT_ARP_TABLE_DEPTH = 32;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ip_arp_resolver_fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: dout always shows the head entry; rd_en on empty is ignored.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 58,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic [MAX_DEPTH_BITS:0] count
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic                      do_rd;

  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ip_arp_resolver.sv
// Next-hop IP->MAC resolver: flop table with aging, 2-stage parallel lookup, in-order result FIFO,
// deduplicated miss request toward the CPU path, and register-side table read/write.
module ip_arp_resolver
  import ip_arp_resolver_pkg::*;
#(
  parameter int NUM_QUEUES      = 8,
  parameter int LUT_DEPTH       = ROUTER_OP_LUT_ARP_TABLE_DEPTH,
  parameter int LUT_DEPTH_BITS  = log2(LUT_DEPTH),
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int AGE_BITS        = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IP_W-1:0]           next_hop_ip,
  input  logic [NUM_QUEUES-1:0]     lpm_output_port,
  input  logic                      lpm_hit,
  input  logic                      lpm_vld,
  output logic                      lookup_rdy,
  output logic [MAC_W-1:0]          next_hop_mac,
  output logic [NUM_QUEUES-1:0]     output_port,
  output logic                      arp_lookup_hit,
  output logic                      lpm_lookup_hit,
  output logic                      arp_mac_vld,
  input  logic                      rd_arp_result,
  output logic                      arp_miss_vld,
  output logic [IP_W-1:0]           arp_miss_ip,
  input  logic                      arp_miss_rdy,
  output logic [15:0]               arp_miss_drops,
  input  logic                      age_tick,
  input  logic [AGE_BITS-1:0]       age_limit,
  input  logic [LUT_DEPTH_BITS-1:0] arp_rd_addr,
  input  logic                      arp_rd_req,
  output logic [MAC_W-1:0]          arp_rd_mac,
  output logic [IP_W-1:0]           arp_rd_ip,
  output logic                      arp_rd_valid,
  output logic [AGE_BITS-1:0]       arp_rd_age,
  output logic                      arp_rd_ack,
  input  logic [LUT_DEPTH_BITS-1:0] arp_wr_addr,
  input  logic                      arp_wr_req,
  input  logic [MAC_W-1:0]          arp_wr_mac,
  input  logic [IP_W-1:0]           arp_wr_ip,
  input  logic                      arp_wr_valid,
  output logic                      arp_wr_ack
);

  localparam int FIFO_W = MAC_W + NUM_QUEUES + 2;
  localparam int OCC_W  = FIFO_DEPTH_BITS + 2;

  function automatic logic [AGE_BITS-1:0] age_sat_inc(input logic [AGE_BITS-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  function automatic logic [15:0] drops_sat_inc(input logic [15:0] d);
    return (&d) ? d : d + 1'b1;
  endfunction

  logic [IP_W-1:0]           tbl_ip  [LUT_DEPTH];
  logic [MAC_W-1:0]          tbl_mac [LUT_DEPTH];
  logic [AGE_BITS-1:0]       tbl_age [LUT_DEPTH];
  logic [LUT_DEPTH-1:0]      tbl_valid;

  logic                      vld_p0, vld_p1;
  logic [IP_W-1:0]           ip_p0, ip_p1;
  logic [NUM_QUEUES-1:0]     port_p0, port_p1;
  logic                      lpm_hit_p0, lpm_hit_p1;
  logic                      arp_hit_p1;
  logic [MAC_W-1:0]          mac_p1;

  logic                      accept;
  logic                      hit_s1;
  logic [LUT_DEPTH_BITS-1:0] idx_s1;
  logic                      refresh;

  logic [FIFO_W-1:0]         fifo_dout;
  logic                      fifo_empty;
  logic [FIFO_DEPTH_BITS:0]  fifo_count;
  logic [OCC_W-1:0]          occupancy;

  logic                      miss_vld;
  logic [IP_W-1:0]           miss_ip;
  logic                      miss_evt, miss_clr, miss_load, miss_drop;

  logic [MAC_W-1:0]          rd_mac_q;
  logic [IP_W-1:0]           rd_ip_q;
  logic                      rd_valid_q;
  logic [AGE_BITS-1:0]       rd_age_q;

  // Pipeline slots plus queued results may never exceed the FIFO depth.
  assign occupancy  = OCC_W'(fifo_count) + OCC_W'(vld_p0) + OCC_W'(vld_p1);
  assign lookup_rdy = occupancy < OCC_W'(1 << FIFO_DEPTH_BITS);
  assign accept     = lpm_vld && lookup_rdy;

  // S0: accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ip_p0      <= next_hop_ip;
      port_p0    <= lpm_output_port;
      lpm_hit_p0 <= lpm_hit;
    end
  end

  // S1: parallel compare, lowest matching index wins
  always_comb begin
    hit_s1 = 1'b0;
    idx_s1 = '0;
    for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
      if (tbl_valid[i] && (tbl_ip[i] == ip_p0)) begin
        hit_s1 = 1'b1;
        idx_s1 = LUT_DEPTH_BITS'(i);
      end
    end
  end

  assign refresh = vld_p0 && hit_s1;

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      ip_p1      <= ip_p0;
      port_p1    <= port_p0;
      lpm_hit_p1 <= lpm_hit_p0;
      arp_hit_p1 <= hit_s1;
      mac_p1     <= hit_s1 ? tbl_mac[idx_s1] : '0;
    end
  end

  // S2: push result, raise or merge miss
  fallthrough_small_fifo #(
    .WIDTH          (FIFO_W),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_result_fifo (
    .clk   (clk),
    .reset (reset),
    .din   ({mac_p1, port_p1, arp_hit_p1, lpm_hit_p1}),
    .wr_en (vld_p1),
    .rd_en (rd_arp_result),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign arp_mac_vld = !fifo_empty;
  assign {next_hop_mac, output_port, arp_lookup_hit, lpm_lookup_hit} = arp_mac_vld ? fifo_dout : '0;

  assign miss_evt  = vld_p1 && lpm_hit_p1 && !arp_hit_p1;
  assign miss_clr  = miss_vld && arp_miss_rdy;
  assign miss_load = miss_evt && (!miss_vld || miss_clr);
  assign miss_drop = miss_evt && miss_vld && !miss_clr && (miss_ip != ip_p1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_vld       <= 1'b0;
      arp_miss_drops <= '0;
    end else begin
      miss_vld <= miss_load || (miss_vld && !miss_clr);
      if (miss_drop) arp_miss_drops <= drops_sat_inc(arp_miss_drops);
    end
  end

  always_ff @(posedge clk) begin
    if (miss_load) miss_ip <= ip_p1;
  end

  assign arp_miss_vld = miss_vld;
  assign arp_miss_ip  = miss_vld ? miss_ip : '0;

  // Table state: write beats hit refresh beats aging.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_valid <= '0;
      for (int i = 0; i < LUT_DEPTH; i++) tbl_age[i] <= '0;
    end else begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        if (arp_wr_req && (arp_wr_addr == LUT_DEPTH_BITS'(i))) begin
          tbl_valid[i] <= arp_wr_valid;
          tbl_age[i]   <= '0;
        end else if (refresh && (idx_s1 == LUT_DEPTH_BITS'(i))) begin
          tbl_age[i] <= '0;
        end else if (age_tick && tbl_valid[i]) begin
          tbl_age[i] <= age_sat_inc(tbl_age[i]);
          if ((age_limit != '0) && (age_sat_inc(tbl_age[i]) >= age_limit)) tbl_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arp_wr_req) begin
      tbl_ip[arp_wr_addr]  <= arp_wr_ip;
      tbl_mac[arp_wr_addr] <= arp_wr_mac;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arp_rd_ack <= 1'b0;
      arp_wr_ack <= 1'b0;
    end else begin
      arp_rd_ack <= arp_rd_req;
      arp_wr_ack <= arp_wr_req;
    end
  end

  always_ff @(posedge clk) begin
    if (arp_rd_req) begin
      rd_mac_q   <= tbl_mac[arp_rd_addr];
      rd_ip_q    <= tbl_ip[arp_rd_addr];
      rd_valid_q <= tbl_valid[arp_rd_addr];
      rd_age_q   <= tbl_age[arp_rd_addr];
    end
  end

  assign arp_rd_mac   = arp_rd_ack ? rd_mac_q   : '0;
  assign arp_rd_ip    = arp_rd_ack ? rd_ip_q    : '0;
  assign arp_rd_valid = arp_rd_ack && rd_valid_q;
  assign arp_rd_age   = arp_rd_ack ? rd_age_q   : '0;

endmodule

// File: tb/tb_ip_arp_resolver.sv
// Directed bench for ip_arp_resolver: lookup latency, miss dedup, FIFO backpressure, aging, priority, reset.
module tb_ip_arp_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_hop_ip;
  logic [7:0]  lpm_output_port;
  logic        lpm_hit, lpm_vld, lookup_rdy;
  logic [47:0] next_hop_mac;
  logic [7:0]  output_port;
  logic        arp_lookup_hit, lpm_lookup_hit, arp_mac_vld, rd_arp_result;
  logic        arp_miss_vld, arp_miss_rdy;
  logic [31:0] arp_miss_ip;
  logic [15:0] arp_miss_drops;
  logic        age_tick;
  logic [7:0]  age_limit;
  logic [4:0]  arp_rd_addr, arp_wr_addr;
  logic        arp_rd_req, arp_rd_ack, arp_rd_valid, arp_wr_req, arp_wr_valid, arp_wr_ack;
  logic [47:0] arp_rd_mac, arp_wr_mac;
  logic [31:0] arp_rd_ip, arp_wr_ip;
  logic [7:0]  arp_rd_age;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ip_arp_resolver dut (
    .clk(clk), .reset(reset),
    .next_hop_ip(next_hop_ip), .lpm_output_port(lpm_output_port), .lpm_hit(lpm_hit),
    .lpm_vld(lpm_vld), .lookup_rdy(lookup_rdy),
    .next_hop_mac(next_hop_mac), .output_port(output_port), .arp_lookup_hit(arp_lookup_hit),
    .lpm_lookup_hit(lpm_lookup_hit), .arp_mac_vld(arp_mac_vld), .rd_arp_result(rd_arp_result),
    .arp_miss_vld(arp_miss_vld), .arp_miss_ip(arp_miss_ip), .arp_miss_rdy(arp_miss_rdy),
    .arp_miss_drops(arp_miss_drops), .age_tick(age_tick), .age_limit(age_limit),
    .arp_rd_addr(arp_rd_addr), .arp_rd_req(arp_rd_req), .arp_rd_mac(arp_rd_mac), .arp_rd_ip(arp_rd_ip),
    .arp_rd_valid(arp_rd_valid), .arp_rd_age(arp_rd_age), .arp_rd_ack(arp_rd_ack),
    .arp_wr_addr(arp_wr_addr), .arp_wr_req(arp_wr_req), .arp_wr_mac(arp_wr_mac), .arp_wr_ip(arp_wr_ip),
    .arp_wr_valid(arp_wr_valid), .arp_wr_ack(arp_wr_ack)
  );

  // Stimulus helpers: entered at a negedge, return at a later negedge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] ip, input logic [47:0] mac, input logic v);
    arp_wr_req = 1'b1; arp_wr_addr = a; arp_wr_ip = ip; arp_wr_mac = mac; arp_wr_valid = v;
    @(negedge clk);
    arp_wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a);
    arp_rd_req = 1'b1; arp_rd_addr = a;
    @(negedge clk);
    arp_rd_req = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] ip, input logic [7:0] port, input logic hit);
    lpm_vld = 1'b1; next_hop_ip = ip; lpm_output_port = port; lpm_hit = hit;
    @(negedge clk);
    lpm_vld = 1'b0;
  endtask

  task automatic do_pop();
    rd_arp_result = 1'b1;
    @(negedge clk);
    rd_arp_result = 1'b0;
  endtask

  task automatic pulse_age();
    age_tick = 1'b1;
    @(negedge clk);
    age_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    lpm_vld = 0; next_hop_ip = 0; lpm_output_port = 0; lpm_hit = 0; rd_arp_result = 0;
    arp_miss_rdy = 0; age_tick = 0; age_limit = 0; arp_rd_addr = 0; arp_rd_req = 0;
    arp_wr_addr = 0; arp_wr_req = 0; arp_wr_mac = 0; arp_wr_ip = 0; arp_wr_valid = 0;
    tick(3);
    checks++; if (arp_mac_vld !== 1'b0) begin errors++; $display("FAIL rst_mac_vld: got %b want 0", arp_mac_vld); end
    checks++; if (lookup_rdy !== 1'b1) begin errors++; $display("FAIL rst_lookup_rdy: got %b want 1", lookup_rdy); end
    checks++; if (arp_miss_vld !== 1'b0 || arp_miss_drops !== 16'd0) begin errors++; $display("FAIL rst_miss: got vld=%b drops=%0d want 0/0", arp_miss_vld, arp_miss_drops); end
    checks++; if (next_hop_mac !== 48'd0 || arp_rd_ack !== 1'b0 || arp_wr_ack !== 1'b0) begin errors++; $display("FAIL rst_outputs: got mac=%h rd_ack=%b wr_ack=%b want 0", next_hop_mac, arp_rd_ack, arp_wr_ack); end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_basic_hit();
    do_write(5'd3, 32'h0A000001, 48'h001122334455, 1'b1);
    checks++; if (arp_wr_ack !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b want 1", arp_wr_ack); end
    do_lookup(32'h0A000001, 8'h04, 1'b1);
    tick(1);
    checks++; if (arp_mac_vld !== 1'b0) begin errors++; $display("FAIL hit_latency_early: got vld=%b want 0", arp_mac_vld); end
    tick(1);
    checks++; if (arp_mac_vld !== 1'b1) begin errors++; $display("FAIL hit_vld: got %b want 1", arp_mac_vld); end
    checks++; if (next_hop_mac !== 48'h001122334455) begin errors++; $display("FAIL hit_mac: got %h want 001122334455", next_hop_mac); end
    checks++; if (output_port !== 8'h04 || arp_lookup_hit !== 1'b1 || lpm_lookup_hit !== 1'b1) begin errors++; $display("FAIL hit_fields: got port=%h arp=%b lpm=%b want 04/1/1", output_port, arp_lookup_hit, lpm_lookup_hit); end
    checks++; if (arp_miss_vld !== 1'b0) begin errors++; $display("FAIL hit_no_miss: got %b want 0", arp_miss_vld); end
    do_pop();
    checks++; if (arp_mac_vld !== 1'b0) begin errors++; $display("FAIL hit_pop: got vld=%b want 0", arp_mac_vld); end
  endtask

  task automatic test_miss();
    do_lookup(32'h0A000099, 8'h04, 1'b1);
    tick(2);
    checks++; if (arp_mac_vld !== 1'b1 || arp_lookup_hit !== 1'b0 || next_hop_mac !== 48'd0) begin errors++; $display("FAIL miss_result: got vld=%b arp=%b mac=%h want 1/0/0", arp_mac_vld, arp_lookup_hit, next_hop_mac); end
    checks++; if (arp_miss_vld !== 1'b1 || arp_miss_ip !== 32'h0A000099) begin errors++; $display("FAIL miss_req: got vld=%b ip=%h want 1/0A000099", arp_miss_vld, arp_miss_ip); end
    do_pop();
    do_lookup(32'h0A000099, 8'h04, 1'b1);
    tick(2);
    checks++; if (arp_miss_drops !== 16'd0 || arp_miss_ip !== 32'h0A000099) begin errors++; $display("FAIL miss_merge: got drops=%0d ip=%h want 0/0A000099", arp_miss_drops, arp_miss_ip); end
    do_pop();
    do_lookup(32'h0A00009A, 8'h04, 1'b1);
    tick(2);
    checks++; if (arp_miss_drops !== 16'd1 || arp_miss_ip !== 32'h0A000099) begin errors++; $display("FAIL miss_drop: got drops=%0d ip=%h want 1/0A000099", arp_miss_drops, arp_miss_ip); end
    do_pop();
    arp_miss_rdy = 1'b1;
    @(negedge clk);
    arp_miss_rdy = 1'b0;
    checks++; if (arp_miss_vld !== 1'b0) begin errors++; $display("FAIL miss_clear: got %b want 0", arp_miss_vld); end
    do_lookup(32'h0A0000AA, 8'h02, 1'b0);
    tick(2);
    checks++; if (arp_mac_vld !== 1'b1 || arp_lookup_hit !== 1'b0 || arp_miss_vld !== 1'b0) begin errors++; $display("FAIL nolpm_no_miss: got vld=%b arp=%b miss=%b want 1/0/0", arp_mac_vld, arp_lookup_hit, arp_miss_vld); end
    do_pop();
  endtask

  task automatic test_fifo_backpressure();
    int acc;
    acc = 0;
    lpm_vld = 1'b1; next_hop_ip = 32'h0A000001; lpm_output_port = 8'h01; lpm_hit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (lookup_rdy) acc++;
      @(negedge clk);
    end
    checks++; if (acc !== 4 || lookup_rdy !== 1'b0) begin errors++; $display("FAIL fifo_fill: got accepted=%0d rdy=%b want 4/0", acc, lookup_rdy); end
    rd_arp_result = 1'b1;
    checks++; if (lookup_rdy !== 1'b0) begin errors++; $display("FAIL fifo_pop_same_cycle: got rdy=%b want 0", lookup_rdy); end
    if (lookup_rdy) acc++;
    @(negedge clk);
    rd_arp_result = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (lookup_rdy) acc++;
      @(negedge clk);
    end
    lpm_vld = 1'b0;
    checks++; if (acc !== 5 || lookup_rdy !== 1'b0) begin errors++; $display("FAIL fifo_one_more: got accepted=%0d rdy=%b want 5/0", acc, lookup_rdy); end
    for (int n = 0; n < 8 && arp_mac_vld; n++) do_pop();
    checks++; if (arp_mac_vld !== 1'b0 || lookup_rdy !== 1'b1) begin errors++; $display("FAIL fifo_drain: got vld=%b rdy=%b want 0/1", arp_mac_vld, lookup_rdy); end
  endtask

  task automatic test_aging();
    do_write(5'd3, 32'h0A000001, 48'h001122334455, 1'b1);
    age_limit = 8'd2;
    pulse_age();
    pulse_age();
    do_read(5'd3);
    checks++; if (arp_rd_ack !== 1'b1 || arp_rd_valid !== 1'b0) begin errors++; $display("FAIL age_expire: got ack=%b valid=%b want 1/0", arp_rd_ack, arp_rd_valid); end
    do_lookup(32'h0A000001, 8'h04, 1'b0);
    tick(2);
    checks++; if (arp_mac_vld !== 1'b1 || arp_lookup_hit !== 1'b0) begin errors++; $display("FAIL age_lookup_miss: got vld=%b arp=%b want 1/0", arp_mac_vld, arp_lookup_hit); end
    do_pop();
    do_write(5'd3, 32'h0A000001, 48'h001122334455, 1'b1);
    pulse_age();
    do_read(5'd3);
    checks++; if (arp_rd_valid !== 1'b1 || arp_rd_age !== 8'd1) begin errors++; $display("FAIL age_one_tick: got valid=%b age=%0d want 1/1", arp_rd_valid, arp_rd_age); end
    do_lookup(32'h0A000001, 8'h04, 1'b0);
    tick(2);
    checks++; if (arp_lookup_hit !== 1'b1) begin errors++; $display("FAIL age_refresh_hit: got %b want 1", arp_lookup_hit); end
    do_pop();
    pulse_age();
    do_read(5'd3);
    checks++; if (arp_rd_valid !== 1'b1 || arp_rd_age !== 8'd1) begin errors++; $display("FAIL age_refreshed: got valid=%b age=%0d want 1/1", arp_rd_valid, arp_rd_age); end
    age_limit = 8'd0;
  endtask

  task automatic test_priority_rdwr();
    do_write(5'd1, 32'h0A000002, 48'h0000AAAA0001, 1'b1);
    do_write(5'd5, 32'h0A000002, 48'h0000BBBB0005, 1'b1);
    do_lookup(32'h0A000002, 8'h02, 1'b0);
    tick(2);
    checks++; if (next_hop_mac !== 48'h0000AAAA0001 || output_port !== 8'h02) begin errors++; $display("FAIL low_index_wins: got mac=%h port=%h want 0000AAAA0001/02", next_hop_mac, output_port); end
    do_pop();
    arp_rd_req = 1'b1; arp_rd_addr = 5'd1;
    arp_wr_req = 1'b1; arp_wr_addr = 5'd1; arp_wr_ip = 32'h0A000002; arp_wr_mac = 48'h0000CCCC0001; arp_wr_valid = 1'b1;
    @(negedge clk);
    arp_rd_req = 1'b0; arp_wr_req = 1'b0;
    checks++; if (arp_rd_ack !== 1'b1 || arp_rd_mac !== 48'h0000AAAA0001) begin errors++; $display("FAIL rdwr_old: got ack=%b mac=%h want 1/0000AAAA0001", arp_rd_ack, arp_rd_mac); end
    do_read(5'd1);
    checks++; if (arp_rd_mac !== 48'h0000CCCC0001 || arp_rd_ip !== 32'h0A000002) begin errors++; $display("FAIL rdwr_new: got mac=%h ip=%h want 0000CCCC0001/0A000002", arp_rd_mac, arp_rd_ip); end
    do_write(5'd1, 32'h0A000002, 48'h0000CCCC0001, 1'b0);
    do_lookup(32'h0A000002, 8'h02, 1'b0);
    tick(2);
    checks++; if (arp_lookup_hit !== 1'b1 || next_hop_mac !== 48'h0000BBBB0005) begin errors++; $display("FAIL delete_falls_to_idx5: got arp=%b mac=%h want 1/0000BBBB0005", arp_lookup_hit, next_hop_mac); end
    do_pop();
  endtask

  task automatic test_reset_midstream();
    do_lookup(32'h0A000002, 8'h01, 1'b0);
    do_lookup(32'h0A000002, 8'h02, 1'b0);
    tick(2);
    checks++; if (arp_mac_vld !== 1'b1) begin errors++; $display("FAIL mid_queued: got vld=%b want 1", arp_mac_vld); end
    #2 reset = 1'b0;
    #1;
    checks++; if (arp_mac_vld !== 1'b0 || next_hop_mac !== 48'd0 || output_port !== 8'd0) begin errors++; $display("FAIL mid_reset_outputs: got vld=%b mac=%h port=%h want 0", arp_mac_vld, next_hop_mac, output_port); end
    @(negedge clk);
    reset = 1'b1;
    checks++; if (lookup_rdy !== 1'b1) begin errors++; $display("FAIL mid_release_rdy: got %b want 1", lookup_rdy); end
    do_read(5'd5);
    checks++; if (arp_rd_valid !== 1'b0) begin errors++; $display("FAIL mid_entry_cleared: got valid=%b want 0", arp_rd_valid); end
    do_lookup(32'h0A000002, 8'h01, 1'b0);
    tick(2);
    checks++; if (arp_mac_vld !== 1'b1 || arp_lookup_hit !== 1'b0) begin errors++; $display("FAIL mid_lookup_miss: got vld=%b arp=%b want 1/0", arp_mac_vld, arp_lookup_hit); end
    do_pop();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_hit();
    test_miss();
    test_fifo_backpressure();
    test_aging();
    test_priority_rdwr();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
